// File: rtl/conv_serial_engine.sv
// conv_serial_engine
// Bit-serial convolution engine. Each transaction computes one KERNEL_SIZE-tap
// dot product of X and K. One K bit-plane is processed per cycle, so a
// transaction takes DATA_WIDTH cycles. The accumulator is preloaded with a bias,
// and the result is optionally passed through ReLU and saturated to OUT_WIDTH.
//
// Ports
//   i_clk, i_rst            clock, synchronous active-high reset
//   i_valid / o_ready       operand handshake (accept only in IDLE)
//   i_x, i_k                packed lanes, lane i at [i*DATA_WIDTH +: DATA_WIDTH]
//   i_bias                  accumulator preload
//   i_signed, i_relu        mode bits, captured at accept
//   o_valid / i_ready       result handshake
//   o_conv, o_sat           saturated result, saturation flag
//   i_perf_clr              clears both performance counters
//   o_perf_cycle_count      cycles spent outside IDLE
//   o_perf_op_count         completed output handshakes
//
// state   | meaning
// IDLE    | o_ready high, waiting for operands
// COMPUTE | one K bit-plane per cycle, b = 0 .. DATA_WIDTH-1
// FINISH  | ReLU + saturation, result registered
// OUTPUT  | o_valid high, result held until i_ready
module conv_serial_engine #(
    parameter int KERNEL_SIZE = 25,
    parameter int DATA_WIDTH  = 8,
    parameter int ACC_WIDTH   = 22,
    parameter int OUT_WIDTH   = 16
) (
    input  logic                              i_clk,
    input  logic                              i_rst,
    input  logic                              i_valid,
    output logic                              o_ready,
    input  logic [KERNEL_SIZE*DATA_WIDTH-1:0] i_x,
    input  logic [KERNEL_SIZE*DATA_WIDTH-1:0] i_k,
    input  logic [ACC_WIDTH-1:0]              i_bias,
    input  logic                              i_signed,
    input  logic                              i_relu,
    output logic                              o_valid,
    input  logic                              i_ready,
    output logic [OUT_WIDTH-1:0]              o_conv,
    output logic                              o_sat,
    input  logic                              i_perf_clr,
    output logic [31:0]                       o_perf_cycle_count,
    output logic [31:0]                       o_perf_op_count
);

    localparam int BW = $clog2(DATA_WIDTH);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

    // Saturation bounds expressed at accumulator width.
    localparam logic [ACC_WIDTH-1:0] U_MAX = {ACC_WIDTH{1'b1}} >> (ACC_WIDTH - OUT_WIDTH);
    localparam logic [ACC_WIDTH-1:0] S_MAX = U_MAX >> 1;
    localparam logic [ACC_WIDTH-1:0] S_MIN = ~S_MAX;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        FINISH  = 2'd2,
        OUTPUT  = 2'd3
    } state_t;

    state_t                            state_q, state_d;
    logic [KERNEL_SIZE*DATA_WIDTH-1:0] x_q, x_d;
    logic [KERNEL_SIZE*DATA_WIDTH-1:0] k_q, k_d;
    logic                              signed_q, signed_d;
    logic                              relu_q, relu_d;
    logic [ACC_WIDTH-1:0]              acc_q, acc_d;
    logic [BW-1:0]                     bit_q, bit_d;
    logic [OUT_WIDTH-1:0]              conv_q, conv_d;
    logic                              sat_q, sat_d;
    logic [31:0]                       cyc_q, cyc_d;
    logic [31:0]                       ops_q, ops_d;

    logic [ACC_WIDTH-1:0]              psum;
    logic [ACC_WIDTH-1:0]              psum_shift;
    logic [ACC_WIDTH-1:0]              relu_val;
    logic [DATA_WIDTH-1:0]             lane;

    // Sum of the X lanes whose current K bit is set.
    always_comb begin
        psum = '0;
        lane = '0;
        for (int i = 0; i < KERNEL_SIZE; i++) begin
            lane = x_q[i*DATA_WIDTH +: DATA_WIDTH];
            if (k_q[i*DATA_WIDTH + int'(bit_q)]) begin
                if (signed_q) begin
                    psum = psum + {{(ACC_WIDTH-DATA_WIDTH){lane[DATA_WIDTH-1]}}, lane};
                end else begin
                    psum = psum + {{(ACC_WIDTH-DATA_WIDTH){1'b0}}, lane};
                end
            end
        end
        psum_shift = psum << bit_q;
    end

    // ReLU only applies to signed results.
    assign relu_val = (signed_q && relu_q && acc_q[ACC_WIDTH-1]) ? '0 : acc_q;

    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        k_d      = k_q;
        signed_d = signed_q;
        relu_d   = relu_q;
        acc_d    = acc_q;
        bit_d    = bit_q;
        conv_d   = conv_q;
        sat_d    = sat_q;
        ops_d    = ops_q;
        cyc_d    = (state_q != IDLE) ? cyc_q + 32'd1 : cyc_q;

        unique case (state_q)
            IDLE: begin
                if (i_valid) begin
                    x_d      = i_x;
                    k_d      = i_k;
                    signed_d = i_signed;
                    relu_d   = i_relu;
                    acc_d    = i_bias;
                    bit_d    = '0;
                    state_d  = COMPUTE;
                end
            end
            COMPUTE: begin
                // In two's complement the MSB plane carries negative weight.
                if (signed_q && bit_q == LAST_BIT) begin
                    acc_d = acc_q - psum_shift;
                end else begin
                    acc_d = acc_q + psum_shift;
                end
                if (bit_q == LAST_BIT) begin
                    state_d = FINISH;
                end else begin
                    bit_d = bit_q + 1'b1;
                end
            end
            FINISH: begin
                sat_d  = 1'b0;
                conv_d = relu_val[OUT_WIDTH-1:0];
                if (signed_q) begin
                    if ($signed(relu_val) > $signed(S_MAX)) begin
                        conv_d = S_MAX[OUT_WIDTH-1:0];
                        sat_d  = 1'b1;
                    end else if ($signed(relu_val) < $signed(S_MIN)) begin
                        conv_d = S_MIN[OUT_WIDTH-1:0];
                        sat_d  = 1'b1;
                    end
                end else if (relu_val > U_MAX) begin
                    conv_d = U_MAX[OUT_WIDTH-1:0];
                    sat_d  = 1'b1;
                end
                state_d = OUTPUT;
            end
            OUTPUT: begin
                if (i_ready) begin
                    ops_d   = ops_q + 32'd1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (i_perf_clr) begin
            cyc_d = '0;
            ops_d = '0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= IDLE;
            x_q      <= '0;
            k_q      <= '0;
            signed_q <= 1'b0;
            relu_q   <= 1'b0;
            acc_q    <= '0;
            bit_q    <= '0;
            conv_q   <= '0;
            sat_q    <= 1'b0;
            cyc_q    <= '0;
            ops_q    <= '0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            k_q      <= k_d;
            signed_q <= signed_d;
            relu_q   <= relu_d;
            acc_q    <= acc_d;
            bit_q    <= bit_d;
            conv_q   <= conv_d;
            sat_q    <= sat_d;
            cyc_q    <= cyc_d;
            ops_q    <= ops_d;
        end
    end

    assign o_ready            = (state_q == IDLE);
    assign o_valid            = (state_q == OUTPUT);
    assign o_conv             = conv_q;
    assign o_sat              = sat_q;
    assign o_perf_cycle_count = cyc_q;
    assign o_perf_op_count    = ops_q;

endmodule

// File: tb/tb_conv_serial_engine.sv
module tb_conv_serial_engine;

    localparam int KS = 25;
    localparam int DW = 8;
    localparam int AW = 22;
    localparam int OW = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              valid_in;
    logic              ready_out;
    logic [KS*DW-1:0]  x_in;
    logic [KS*DW-1:0]  k_in;
    logic [AW-1:0]     bias;
    logic              sgn;
    logic              relu;
    logic              valid_out;
    logic              ready_in;
    logic [OW-1:0]     conv;
    logic              sat;
    logic              perf_clr;
    logic [31:0]       cyc_cnt;
    logic [31:0]       op_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    logic [OW-1:0] held;

    conv_serial_engine #(
        .KERNEL_SIZE(KS), .DATA_WIDTH(DW), .ACC_WIDTH(AW), .OUT_WIDTH(OW)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_valid(valid_in), .o_ready(ready_out),
        .i_x(x_in), .i_k(k_in), .i_bias(bias), .i_signed(sgn), .i_relu(relu),
        .o_valid(valid_out), .i_ready(ready_in), .o_conv(conv), .o_sat(sat),
        .i_perf_clr(perf_clr), .o_perf_cycle_count(cyc_cnt), .o_perf_op_count(op_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_all(input logic [DW-1:0] xv, input logic [DW-1:0] kv);
        for (int i = 0; i < KS; i++) begin
            x_in[i*DW +: DW] = xv;
            k_in[i*DW +: DW] = kv;
        end
    endtask

    task automatic set_lane0(input logic [DW-1:0] xv, input logic [DW-1:0] kv);
        set_all(8'd0, 8'd0);
        x_in[DW-1:0] = xv;
        k_in[DW-1:0] = kv;
    endtask

    task automatic start_op();
        valid_in = 1'b1;
        tick();
        valid_in = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!valid_out && n < 20) begin
            tick();
            n++;
        end
        chk(tag, {63'd0, valid_out}, 64'd1);
    endtask

    task automatic finish_op();
        ready_in = 1'b1;
        tick();
        ready_in = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [OW-1:0] exp_conv, input logic exp_sat);
        start_op();
        wait_valid({tag, "_timeout"});
        chk({tag, "_conv"}, {48'd0, conv}, {48'd0, exp_conv});
        chk({tag, "_sat"}, {63'd0, sat}, {63'd0, exp_sat});
        finish_op();
    endtask

    initial begin
        rst = 1'b1; valid_in = 1'b0; ready_in = 1'b0; perf_clr = 1'b0;
        sgn = 1'b0; relu = 1'b0; bias = '0;
        set_all(8'd0, 8'd0);
        tick(); tick();
        rst = 1'b0;

        chk("rst_ready", {63'd0, ready_out}, 64'd1);
        chk("rst_valid", {63'd0, valid_out}, 64'd0);
        chk("rst_conv", {48'd0, conv}, 64'd0);
        chk("rst_sat", {63'd0, sat}, 64'd0);
        chk("rst_cyc", {32'd0, cyc_cnt}, 64'd0);
        chk("rst_ops", {32'd0, op_cnt}, 64'd0);

        // Unsigned ones, exact latency: o_valid rises 9 edges after accept.
        set_all(8'd1, 8'd1);
        start_op();
        chk("busy_ready", {63'd0, ready_out}, 64'd0);
        for (int i = 1; i < 9; i++) tick();
        chk("lat_valid_early", {63'd0, valid_out}, 64'd0);
        tick();
        chk("lat_valid", {63'd0, valid_out}, 64'd1);
        chk("ones_conv", {48'd0, conv}, 64'd25);
        chk("ones_sat", {63'd0, sat}, 64'd0);
        finish_op();
        chk("hs_valid", {63'd0, valid_out}, 64'd0);
        chk("hs_ready", {63'd0, ready_out}, 64'd1);

        // Unsigned max: 1625625 clamps to 65535.
        set_all(8'hFF, 8'hFF);
        run_op("umax", 16'hFFFF, 1'b1);

        // Unsigned with relu set: relu ignored, large bias saturates high.
        set_all(8'd0, 8'd0);
        bias = 22'h200000; relu = 1'b1;
        run_op("urelu", 16'hFFFF, 1'b1);
        relu = 1'b0; bias = '0;

        // Signed lane0 -128 * 127 = -16256.
        sgn = 1'b1;
        set_lane0(8'h80, 8'h7F);
        run_op("s_neg", 16'hC080, 1'b0);
        relu = 1'b1;
        run_op("s_relu", 16'h0000, 1'b0);
        relu = 1'b0;

        // Signed negative saturation through bias.
        set_all(8'd0, 8'd0);
        bias = 22'(-40000);
        run_op("s_negsat", 16'h8000, 1'b1);
        bias = '0;

        // Signed -128 * -128 = 16384, then hold under backpressure.
        set_lane0(8'h80, 8'h80);
        start_op();
        wait_valid("bp_timeout");
        chk("s_pos_conv", {48'd0, conv}, 64'h4000);
        held = conv;
        set_all(8'd1, 8'd1);
        for (int i = 0; i < 5; i++) begin
            valid_in = i[0];
            tick();
            chk("bp_valid", {63'd0, valid_out}, 64'd1);
            chk("bp_ready", {63'd0, ready_out}, 64'd0);
            chk("bp_conv", {48'd0, conv}, {48'd0, held});
        end
        valid_in = 1'b0;
        finish_op();
        chk("bp_hs_valid", {63'd0, valid_out}, 64'd0);
        chk("bp_hs_ready", {63'd0, ready_out}, 64'd1);
        sgn = 1'b0;

        // Reset during COMPUTE at bit 3.
        set_all(8'd1, 8'd1);
        start_op();
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_ready", {63'd0, ready_out}, 64'd1);
        chk("mid_rst_valid", {63'd0, valid_out}, 64'd0);
        chk("mid_rst_cyc", {32'd0, cyc_cnt}, 64'd0);
        chk("mid_rst_ops", {32'd0, op_cnt}, 64'd0);
        set_all(8'd0, 8'd0);
        bias = 22'd100;
        run_op("bias", 16'd100, 1'b0);

        // Perf counters over two ops.
        perf_clr = 1'b1;
        tick();
        perf_clr = 1'b0;
        chk("clr_cyc", {32'd0, cyc_cnt}, 64'd0);
        chk("clr_ops", {32'd0, op_cnt}, 64'd0);
        run_op("p1", 16'd100, 1'b0);
        run_op("p2", 16'd100, 1'b0);
        chk("perf_cyc", {32'd0, cyc_cnt}, 64'd20);
        chk("perf_ops", {32'd0, op_cnt}, 64'd2);

        // Clear mid-op, then resume counting.
        start_op();
        tick(); tick();
        perf_clr = 1'b1;
        tick();
        perf_clr = 1'b0;
        chk("midclr_cyc", {32'd0, cyc_cnt}, 64'd0);
        chk("midclr_ops", {32'd0, op_cnt}, 64'd0);
        tick();
        chk("resume_cyc", {32'd0, cyc_cnt}, 64'd1);
        wait_valid("p3_timeout");
        finish_op();
        chk("resume_ops", {32'd0, op_cnt}, 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
